// File: rtl/pa_rst_req_ctrl.sv
// rtl/pa_rst_req_ctrl.sv - outbound CPU reset-request generator
// Arbitrates sw/had/wdt requests into a min-width active-low request with ack/timeout handshake.
module pa_rst_req_ctrl #(
  parameter int REQ_HOLD_CYC = 16,
  parameter int ACK_TIMEOUT  = 1024,
  parameter int CNT_W        = 11
) (
  input  logic       forever_cpuclk,
  input  logic       async_ciu_rst_b,
  input  logic       pad_yy_scan_mode,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  input  logic       had_rst_req,
  input  logic       soc_rst_ack,
  output logic       rst_req_b,
  output logic [1:0] rst_req_cause,
  output logic       rst_req_busy,
  output logic       rst_req_timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_HAD  = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REQ_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ACK_TIMEOUT - 1);

  logic             had_s1_q, had_s2_q, had_s3_q;
  logic             ack_s1_q, ack_s2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             timeout_q, timeout_d;
  logic             req_b_q, req_b_d;
  logic             busy_q, busy_d;
  logic             had_rise, ack_s, req_any;

  assign had_rise = had_s2_q & ~had_s3_q;
  assign ack_s    = ack_s2_q;
  assign req_any  = ~pad_yy_scan_mode & (wdt_rst_req | had_rise | sw_rst_req);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          if (wdt_rst_req)   cause_d = CAUSE_WDT;
          else if (had_rise) cause_d = CAUSE_HAD;
          else               cause_d = CAUSE_SW;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // an ack arriving on the terminal count still counts as acknowledged
        if (ack_s) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          cause_d   = CAUSE_NONE;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (!ack_s) begin
          cause_d = CAUSE_NONE;
          state_d = ST_IDLE;
        end
      end
    endcase
    req_b_d = ~((state_d == ST_ASSERT) || (state_d == ST_WAIT));
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge forever_cpuclk or negedge async_ciu_rst_b) begin
    if (!async_ciu_rst_b) begin
      had_s1_q  <= 1'b0;
      had_s2_q  <= 1'b0;
      had_s3_q  <= 1'b0;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cause_q   <= CAUSE_NONE;
      timeout_q <= 1'b0;
      req_b_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      had_s1_q  <= had_rst_req;
      had_s2_q  <= had_s1_q;
      had_s3_q  <= had_s2_q;
      ack_s1_q  <= soc_rst_ack;
      ack_s2_q  <= ack_s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      timeout_q <= timeout_d;
      req_b_q   <= req_b_d;
      busy_q    <= busy_d;
    end
  end

  // scan mode must never let a reset request reach the SoC, even mid-flight
  assign rst_req_b       = req_b_q | pad_yy_scan_mode;
  assign rst_req_cause   = cause_q;
  assign rst_req_busy    = busy_q;
  assign rst_req_timeout = timeout_q;

endmodule

// File: tb/tb_pa_rst_req_ctrl.sv
// tb/tb_pa_rst_req_ctrl.sv - directed self-checking bench for pa_rst_req_ctrl
module tb_pa_rst_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       scan = 1'b0;
  logic       sw = 1'b0;
  logic       wdt = 1'b0;
  logic       had = 1'b0;
  logic       ack = 1'b0;
  logic       req_b;
  logic [1:0] cause;
  logic       busy;
  logic       tout;

  int n_chk = 0;
  int n_err = 0;

  pa_rst_req_ctrl #(.REQ_HOLD_CYC(16), .ACK_TIMEOUT(8), .CNT_W(11)) u_dut (
    .forever_cpuclk   (clk),
    .async_ciu_rst_b  (rst_b),
    .pad_yy_scan_mode (scan),
    .sw_rst_req       (sw),
    .wdt_rst_req      (wdt),
    .had_rst_req      (had),
    .soc_rst_ack      (ack),
    .rst_req_b        (req_b),
    .rst_req_cause    (cause),
    .rst_req_busy     (busy),
    .rst_req_timeout  (tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle pulse; returns #1 after the edge that sampled it
  task automatic pulse(input logic p_sw, input logic p_wdt);
    sw  = p_sw;
    wdt = p_wdt;
    tick();
    sw  = 1'b0;
    wdt = 1'b0;
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (req_b == 1'b0 && n < 3000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      k++;
      tick();
    end
    chk(tag, busy, 0);
  endtask

  int n_low;
  int starts;
  logic prev_b;
  logic [1:0] first_cause;
  logic bad;

  initial begin
    tick(3);
    chk("rst_req_b", req_b, 1);
    chk("rst_cause", cause, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tout", tout, 0);
    rst_b = 1'b1;
    tick(3);

    // software request, fast ack
    pulse(1'b1, 1'b0);
    chk("sw_req_b_n1", req_b, 0);
    chk("sw_busy_n1", busy, 1);
    chk("sw_cause", cause, 2'b01);
    tick();
    ack = 1'b1;
    tick();
    n_low = 2;
    begin
      int more;
      count_low(more);
      n_low += more;
    end
    chk("sw_low_len", n_low, 17);
    chk("sw_rel_cause", cause, 2'b01);
    chk("sw_rel_busy", busy, 1);
    tick(5);
    ack = 1'b0;
    tick(2);
    chk("sw_ackfall_busy", busy, 1);
    chk("sw_ackfall_cause", cause, 2'b01);
    tick();
    chk("sw_done_busy", busy, 0);
    chk("sw_done_cause", cause, 0);
    chk("sw_done_req_b", req_b, 1);
    chk("sw_done_tout", tout, 0);
    tick(3);

    // simultaneous wdt+sw, then a dropped sw while busy
    ack = 1'b1;
    pulse(1'b1, 1'b1);
    chk("sim_cause", cause, 2'b11);
    tick(3);
    pulse(1'b1, 1'b0);
    chk("sim_late_cause", cause, 2'b11);
    tick(18);
    chk("sim_rel_req_b", req_b, 1);
    chk("sim_rel_busy", busy, 1);
    ack = 1'b0;
    wait_idle("sim_idle");
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy || !req_b) bad = 1'b1;
      tick();
    end
    chk("sim_no_second", bad, 0);

    // timeout with no ack
    pulse(1'b1, 1'b0);
    count_low(n_low);
    chk("to_low_len", n_low, 24);
    chk("to_flag", tout, 1);
    chk("to_cause", cause, 0);
    chk("to_busy", busy, 0);
    tick(2);
    pulse(1'b1, 1'b0);
    chk("to_clear", tout, 0);
    chk("to_busy2", busy, 1);
    wait_idle("to_idle");
    chk("to_flag2", tout, 1);

    // debug level request
    had = 1'b1;
    starts = 0;
    prev_b = 1'b1;
    first_cause = 2'b00;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (prev_b && !req_b) begin
        starts++;
        if (starts == 1) first_cause = cause;
      end
      prev_b = req_b;
    end
    chk("had_starts", starts, 1);
    chk("had_cause", first_cause, 2'b10);
    had = 1'b0;
    tick(4);
    had = 1'b1;
    tick(2);
    chk("had2_early", req_b, 1);
    tick(2);
    chk("had2_req_b", req_b, 0);
    chk("had2_cause", cause, 2'b10);
    wait_idle("had2_idle");
    had = 1'b0;
    tick(4);

    // scan mode blocks new requests
    scan = 1'b1;
    bad = 1'b0;
    sw = 1'b1;
    wdt = 1'b1;
    had = 1'b1;
    tick();
    sw = 1'b0;
    wdt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy || !req_b) bad = 1'b1;
      tick();
    end
    chk("scan_blocked", bad, 0);
    had = 1'b0;
    tick(4);
    scan = 1'b0;
    tick();

    // scan forces the output high while a request is in flight
    pulse(1'b1, 1'b0);
    chk("scan_pre_req_b", req_b, 0);
    scan = 1'b1;
    #1;
    chk("scan_force_req_b", req_b, 1);
    chk("scan_force_busy", busy, 1);
    tick(2);
    scan = 1'b0;
    wait_idle("scan_idle");

    // asynchronous reset while waiting for ack
    pulse(1'b1, 1'b0);
    tick(17);
    chk("mid_req_b", req_b, 0);
    chk("mid_busy", busy, 1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_req_b", req_b, 1);
    chk("arst_cause", cause, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tout", tout, 0);
    tick(2);
    rst_b = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
